// File: rtl/ltpi_rx_pkg.sv
// LTPI receive-path shared definitions: comma symbol, receiver state
// encoding and the byte-serial CRC-8 step (poly 0x07, MSB first, no
// reflection). The CRC step is also used by the transmit encoder.
package ltpi_rx_pkg;

  localparam logic [7:0] LTPI_COMMA_BYTE = 8'hBC;  // K28.5
  localparam logic [7:0] CRC8_POLY       = 8'h07;

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    CHECK,
    EXPECT_COMMA
  } rx_state_t;

  // One byte of CRC-8: fold the byte in, then shift out eight bits.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ltpi_crc8.sv
// Byte-serial CRC-8 register. Clear has priority over enable so a new frame
// can start on the same cycle the previous one is abandoned.
module ltpi_crc8
  import ltpi_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  // Accumulate one byte per enabled cycle.
  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= 8'h00;
    end else if (i_clr) begin
      r_crc <= 8'h00;
    end else if (i_en) begin
      r_crc <= crc8_byte(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/ltpi_frame_rx.sv
// LTPI receive frame decoder. Hunts for the K28.5 comma, collects
// FRAME_LEN-byte frames, checks CRC-8 over bytes 1..FRAME_LEN-2 against the
// last byte, and tracks alignment with LOCK_CNT/UNLOCK_CNT hysteresis.
// All outputs are registered: a decision taken in the CHECK cycle (or on a
// bad comma/non-comma byte) is visible on the outputs from the next edge.
// Optional macro LTPI_RX_ERR_STATS_EN adds saturating error counters
// (crc_err_cnt, code_err_cnt, unlock_cnt) with a synchronous stats_clr.
module ltpi_frame_rx
  import ltpi_rx_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter logic [7:0]  COMMA_BYTE = LTPI_COMMA_BYTE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_k,
  input  logic                        rx_valid,
  input  logic                        rx_code_err,
  output logic [8*(FRAME_LEN-2)-1:0]  frm_payload,
  output logic                        frm_valid,
  output logic                        frm_crc_err,
  output logic                        aligned,
  output logic [15:0]                 good_frame_cnt
`ifdef LTPI_RX_ERR_STATS_EN
  ,
  input  logic                        stats_clr,
  output logic [15:0]                 crc_err_cnt,
  output logic [15:0]                 code_err_cnt,
  output logic [7:0]                  unlock_cnt
`endif
);

  localparam int unsigned PAY_BYTES = FRAME_LEN - 2;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
  localparam int unsigned GRUN_W    = $clog2(LOCK_CNT + 1);
  localparam int unsigned BRUN_W    = $clog2(UNLOCK_CNT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);  // CRC byte
  localparam logic [IDX_W-1:0]  CRC_LAST = IDX_W'(FRAME_LEN - 2);  // last CRC-covered byte
  localparam logic [GRUN_W-1:0] LOCK_V   = GRUN_W'(LOCK_CNT);
  localparam logic [BRUN_W-1:0] UNLOCK_V = BRUN_W'(UNLOCK_CNT);

  rx_state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_bad;       // code error or stray K seen in this frame
  logic [7:0]              r_crc_rx;    // received CRC byte
  logic [GRUN_W-1:0]       r_good_run;
  logic [BRUN_W-1:0]       r_bad_run;
  logic                    r_aligned;
  logic                    r_frm_valid;
  logic                    r_crc_err;
  logic [8*PAY_BYTES-1:0]  r_buf;
  logic [8*PAY_BYTES-1:0]  r_payload;
  logic [15:0]             r_good_cnt;

  logic                    w_is_comma;
  logic                    w_start, w_store, w_good_evt, w_bad_evt, w_unlock;
  logic                    w_lock, w_emit, w_frame_ok;
  logic [7:0]              w_crc;
  logic [GRUN_W-1:0]       w_good_sat;
  logic [BRUN_W-1:0]       w_bad_sat;

  assign w_is_comma = rx_k && (rx_data == COMMA_BYTE);
  assign w_frame_ok = !r_bad && (w_crc == r_crc_rx);
  assign w_good_sat = (r_good_run == LOCK_V)   ? r_good_run : r_good_run + 1'b1;
  assign w_bad_sat  = (r_bad_run  == UNLOCK_V) ? r_bad_run  : r_bad_run  + 1'b1;
  assign w_lock     = w_good_evt && (w_good_sat == LOCK_V);
  assign w_emit     = w_good_evt && (r_aligned || w_lock);

  ltpi_crc8 u_crc (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_start),
    .i_en   (w_store && (r_idx <= CRC_LAST)),
    .i_data (rx_data),
    .o_crc  (w_crc)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= HUNT;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-cycle frame events.
  // NOTE: every signal gets a default before the case; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_store     = 1'b0;
    w_good_evt  = 1'b0;
    w_bad_evt   = 1'b0;
    w_unlock    = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (rx_valid && w_is_comma) begin
          w_start     = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          if (w_is_comma) begin
            // Comma mid-frame: current frame is bad, resync on this comma.
            w_bad_evt = 1'b1;
            w_start   = 1'b1;
          end else begin
            w_store = 1'b1;
            if (r_idx == LAST_IDX) w_state_nxt = CHECK;
          end
        end
      end
      CHECK: begin
        // Consumes no byte, so it does not wait for rx_valid.
        if (w_frame_ok) w_good_evt = 1'b1;
        else            w_bad_evt  = 1'b1;
        w_state_nxt = EXPECT_COMMA;
      end
      EXPECT_COMMA: begin
        if (rx_valid) begin
          if (w_is_comma) begin
            w_start     = 1'b1;
            w_state_nxt = COLLECT;
          end else begin
            w_bad_evt   = 1'b1;
            w_state_nxt = r_aligned ? EXPECT_COMMA : HUNT;
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
    // Too many bad frames in a row: drop back to hunting.
    if (w_bad_evt && (w_bad_sat == UNLOCK_V)) begin
      w_unlock    = 1'b1;
      w_start     = 1'b0;
      w_state_nxt = HUNT;
    end
  end

  // Frame bookkeeping, alignment hysteresis and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= '0;
      r_bad       <= 1'b0;
      r_crc_rx    <= 8'h00;
      r_good_run  <= '0;
      r_bad_run   <= '0;
      r_aligned   <= 1'b0;
      r_frm_valid <= 1'b0;
      r_crc_err   <= 1'b0;
      r_payload   <= '0;
      r_good_cnt  <= 16'h0000;
    end else begin
      r_frm_valid <= w_emit;
      r_crc_err   <= w_bad_evt;
      if (w_start) begin
        r_idx <= IDX_W'(1);
        r_bad <= rx_code_err;
      end else if (w_store) begin
        r_idx <= r_idx + 1'b1;
        r_bad <= r_bad | rx_code_err | rx_k;
        if (r_idx == LAST_IDX) r_crc_rx <= rx_data;
      end
      if (w_good_evt) begin
        r_good_run <= w_good_sat;
        r_bad_run  <= '0;
      end
      if (w_bad_evt) begin
        r_bad_run  <= w_bad_sat;
        r_good_run <= '0;
      end
      if (w_lock)        r_aligned <= 1'b1;
      else if (w_unlock) r_aligned <= 1'b0;
      if (w_emit) begin
        r_payload <= r_buf;
        if (r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 1'b1;
      end
    end
  end

  // Payload capture buffer; only copied out after a full good frame.
  // NOTE: this storage has no reset: its contents are never observed before
  // every byte has been rewritten by a complete frame.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(PAY_BYTES); i++) begin
      if (w_store && (r_idx == IDX_W'(i + 1))) r_buf[8*i +: 8] <= rx_data;
    end
  end

  assign frm_payload    = r_payload;
  assign frm_valid      = r_frm_valid;
  assign frm_crc_err    = r_crc_err;
  assign aligned        = r_aligned;
  assign good_frame_cnt = r_good_cnt;

`ifdef LTPI_RX_ERR_STATS_EN
  logic [15:0] r_crc_err_cnt;
  logic [15:0] r_code_err_cnt;
  logic [7:0]  r_unlock_cnt;
  logic        w_crc_mis;

  assign w_crc_mis = (r_state == CHECK) && (w_crc != r_crc_rx);

  // Saturating error statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc_err_cnt  <= 16'h0000;
      r_code_err_cnt <= 16'h0000;
      r_unlock_cnt   <= 8'h00;
    end else if (stats_clr) begin
      r_crc_err_cnt  <= 16'h0000;
      r_code_err_cnt <= 16'h0000;
      r_unlock_cnt   <= 8'h00;
    end else begin
      if (w_crc_mis && (r_crc_err_cnt != 16'hFFFF))
        r_crc_err_cnt <= r_crc_err_cnt + 1'b1;
      if (rx_valid && rx_code_err && (r_code_err_cnt != 16'hFFFF))
        r_code_err_cnt <= r_code_err_cnt + 1'b1;
      if (w_unlock && r_aligned && (r_unlock_cnt != 8'hFF))
        r_unlock_cnt <= r_unlock_cnt + 1'b1;
    end
  end

  assign crc_err_cnt  = r_crc_err_cnt;
  assign code_err_cnt = r_code_err_cnt;
  assign unlock_cnt   = r_unlock_cnt;
`endif

endmodule

// File: tb/tb_ltpi_frame_rx.sv
// Directed bench for ltpi_frame_rx: lock, CRC error, unlock/relock, gapped
// input after garbage, mid-frame comma resync, asynchronous reset mid-frame,
// and (with LTPI_RX_ERR_STATS_EN) the error statistics counters.
module tb_ltpi_frame_rx;

  localparam int FRAME_LEN = 16;
  localparam int PAY_W     = 8 * (FRAME_LEN - 2);

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_k;
  logic             rx_valid;
  logic             rx_code_err;
  logic             stats_clr;
  logic [PAY_W-1:0] frm_payload;
  logic             frm_valid;
  logic             frm_crc_err;
  logic             aligned;
  logic [15:0]      good_frame_cnt;
`ifdef LTPI_RX_ERR_STATS_EN
  logic [15:0]      crc_err_cnt;
  logic [15:0]      code_err_cnt;
  logic [7:0]       unlock_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int mon_valid = 0;
  int mon_err   = 0;

  logic [7:0]       fb [FRAME_LEN];
  logic [PAY_W-1:0] exp_pay;
  logic [PAY_W-1:0] last_pay;

  ltpi_frame_rx #(
    .FRAME_LEN  (FRAME_LEN),
    .LOCK_CNT   (3),
    .UNLOCK_CNT (4),
    .COMMA_BYTE (8'hBC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_k           (rx_k),
    .rx_valid       (rx_valid),
    .rx_code_err    (rx_code_err),
    .frm_payload    (frm_payload),
    .frm_valid      (frm_valid),
    .frm_crc_err    (frm_crc_err),
    .aligned        (aligned),
    .good_frame_cnt (good_frame_cnt)
`ifdef LTPI_RX_ERR_STATS_EN
    ,
    .stats_clr      (stats_clr),
    .crc_err_cnt    (crc_err_cnt),
    .code_err_cnt   (code_err_cnt),
    .unlock_cnt     (unlock_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Pulse monitor: a pulse held for two cycles is counted twice.
  always @(negedge clk) begin
    if (frm_valid === 1'b1)   mon_valid++;
    if (frm_crc_err === 1'b1) mon_err++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rx_valid = 1'b0; rx_data = 8'h00; rx_k = 1'b0; rx_code_err = 1'b0;
    tick();
  endtask

  // Gap cycle carrying a comma-looking, erroneous byte that must be ignored.
  task automatic gap;
    rx_valid = 1'b0; rx_data = 8'hBC; rx_k = 1'b1; rx_code_err = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic k, input logic ce);
    rx_valid = 1'b1; rx_data = d; rx_k = k; rx_code_err = ce;
    tick();
  endtask

  // Comma, subtype, bytes 0x10.., bit-serial CRC-8 (0x07) over bytes 1..14.
  task automatic build_frame(input logic [7:0] st, input int flip_idx);
    logic [7:0] c;
    logic       fbk;
    fb[0] = 8'hBC;
    fb[1] = st;
    for (int i = 2; i < FRAME_LEN - 1; i++) fb[i] = 8'h10 + 8'(i - 2);
    c = 8'h00;
    for (int i = 1; i <= FRAME_LEN - 2; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fbk = c[7] ^ fb[i][b];
        c   = {c[6:0], 1'b0};
        if (fbk) c = c ^ 8'h07;
      end
    end
    fb[FRAME_LEN-1] = c;
    for (int i = 1; i <= FRAME_LEN - 2; i++) exp_pay[8*(i-1) +: 8] = fb[i];
    if (flip_idx >= 0) fb[flip_idx][0] = ~fb[flip_idx][0];
  endtask

  // Whole frame plus the CHECK cycle (rx_valid low after the CRC byte).
  task automatic send_frame(input bit gaps, input int ce_idx, input bit clr);
    for (int i = 0; i < FRAME_LEN; i++) begin
      send_byte(fb[i], (i == 0), (i == ce_idx));
      if (gaps && i != FRAME_LEN - 1) gap();
    end
    stats_clr = clr;
    if (gaps) gap();
    else      idle();
    stats_clr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; stats_clr = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; rx_k = 1'b0; rx_code_err = 1'b0;
    tick(); tick();
    n_total++; if (frm_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", frm_valid); else n_pass++;
    n_total++; if (frm_crc_err !== 1'b0) $display("FAIL rst_crc_err: got %b want 0", frm_crc_err); else n_pass++;
    n_total++; if (aligned !== 1'b0) $display("FAIL rst_aligned: got %b want 0", aligned); else n_pass++;
    n_total++; if (good_frame_cnt !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", good_frame_cnt); else n_pass++;
    n_total++; if (frm_payload !== '0) $display("FAIL rst_payload: got %h want 0", frm_payload); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_clean_lock;
    int mv, me;
    logic exp_v;
    mv = mon_valid; me = mon_err;
    build_frame(8'h01, -1);
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b0, -1, 1'b0);
      exp_v = (f == 2);
      n_total++; if (aligned !== exp_v) $display("FAIL lock_aligned_f%0d: got %b want %b", f, aligned, exp_v); else n_pass++;
      n_total++; if (frm_valid !== exp_v) $display("FAIL lock_valid_f%0d: got %b want %b", f, frm_valid, exp_v); else n_pass++;
    end
    n_total++; if (frm_payload[7:0] !== 8'h01) $display("FAIL lock_subtype: got %h want 01", frm_payload[7:0]); else n_pass++;
    n_total++; if (frm_payload !== exp_pay) $display("FAIL lock_payload: got %h want %h", frm_payload, exp_pay); else n_pass++;
    n_total++; if (good_frame_cnt !== 16'd1) $display("FAIL lock_cnt: got %0d want 1", good_frame_cnt); else n_pass++;
    idle();
    n_total++; if (frm_valid !== 1'b0) $display("FAIL lock_pulse_width: got %b want 0", frm_valid); else n_pass++;
    n_total++; if (mon_valid - mv !== 1) $display("FAIL lock_valid_pulses: got %0d want 1", mon_valid - mv); else n_pass++;
    n_total++; if (mon_err - me !== 0) $display("FAIL lock_err_pulses: got %0d want 0", mon_err - me); else n_pass++;
  endtask

  task automatic test_crc_error;
    build_frame(8'h02, -1);
    send_frame(1'b0, -1, 1'b0);
    last_pay = exp_pay;
    n_total++; if (frm_valid !== 1'b1) $display("FAIL crc_pre_valid: got %b want 1", frm_valid); else n_pass++;
    build_frame(8'h03, 5);
    send_frame(1'b0, -1, 1'b0);
    n_total++; if (frm_crc_err !== 1'b1) $display("FAIL crc_err_pulse: got %b want 1", frm_crc_err); else n_pass++;
    n_total++; if (frm_valid !== 1'b0) $display("FAIL crc_no_valid: got %b want 0", frm_valid); else n_pass++;
    n_total++; if (aligned !== 1'b1) $display("FAIL crc_aligned: got %b want 1", aligned); else n_pass++;
    n_total++; if (frm_payload !== last_pay) $display("FAIL crc_payload_hold: got %h want %h", frm_payload, last_pay); else n_pass++;
    n_total++; if (good_frame_cnt !== 16'd2) $display("FAIL crc_cnt: got %0d want 2", good_frame_cnt); else n_pass++;
  endtask

  task automatic test_unlock;
    logic exp_a;
    build_frame(8'h04, -1);
    send_frame(1'b0, -1, 1'b0);
    n_total++; if (frm_valid !== 1'b1) $display("FAIL unl_pre_valid: got %b want 1", frm_valid); else n_pass++;
    build_frame(8'h04, 5);
    for (int f = 0; f < 4; f++) begin
      send_frame(1'b0, -1, 1'b0);
      exp_a = (f < 3);
      n_total++; if (aligned !== exp_a) $display("FAIL unl_aligned_b%0d: got %b want %b", f, aligned, exp_a); else n_pass++;
      n_total++; if (frm_crc_err !== 1'b1) $display("FAIL unl_err_b%0d: got %b want 1", f, frm_crc_err); else n_pass++;
    end
    build_frame(8'h04, -1);
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b0, -1, 1'b0);
      exp_a = (f == 2);
      n_total++; if (frm_valid !== exp_a) $display("FAIL relock_valid_g%0d: got %b want %b", f, frm_valid, exp_a); else n_pass++;
      n_total++; if (aligned !== exp_a) $display("FAIL relock_aligned_g%0d: got %b want %b", f, aligned, exp_a); else n_pass++;
    end
    n_total++; if (good_frame_cnt !== 16'd4) $display("FAIL relock_cnt: got %0d want 4", good_frame_cnt); else n_pass++;
  endtask

  task automatic test_gaps;
    int mv, me;
    logic exp_v;
    reset = 1'b1; tick(); reset = 1'b0;
    mv = mon_valid; me = mon_err;
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b1, 1'b0);
    send_byte(8'hF7, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    build_frame(8'h01, -1);
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b1, -1, 1'b0);
      exp_v = (f == 2);
      n_total++; if (frm_valid !== exp_v) $display("FAIL gap_valid_f%0d: got %b want %b", f, frm_valid, exp_v); else n_pass++;
    end
    n_total++; if (aligned !== 1'b1) $display("FAIL gap_aligned: got %b want 1", aligned); else n_pass++;
    n_total++; if (frm_payload !== exp_pay) $display("FAIL gap_payload: got %h want %h", frm_payload, exp_pay); else n_pass++;
    n_total++; if (good_frame_cnt !== 16'd1) $display("FAIL gap_cnt: got %0d want 1", good_frame_cnt); else n_pass++;
    idle();
    n_total++; if (mon_valid - mv !== 1) $display("FAIL gap_valid_pulses: got %0d want 1", mon_valid - mv); else n_pass++;
    n_total++; if (mon_err - me !== 0) $display("FAIL gap_err_pulses: got %0d want 0", mon_err - me); else n_pass++;
  endtask

  task automatic test_midframe_comma_reset;
    int mv, me;
    me = mon_err;
    build_frame(8'h05, -1);
    for (int i = 0; i < 7; i++) send_byte(fb[i], (i == 0), 1'b0);
    send_byte(8'hBC, 1'b1, 1'b0);
    n_total++; if (frm_crc_err !== 1'b1) $display("FAIL mid_comma_err: got %b want 1", frm_crc_err); else n_pass++;
    n_total++; if (aligned !== 1'b1) $display("FAIL mid_comma_aligned: got %b want 1", aligned); else n_pass++;
    for (int i = 1; i < FRAME_LEN; i++) send_byte(fb[i], 1'b0, 1'b0);
    idle();
    n_total++; if (frm_valid !== 1'b1) $display("FAIL resync_valid: got %b want 1", frm_valid); else n_pass++;
    n_total++; if (frm_payload !== exp_pay) $display("FAIL resync_payload: got %h want %h", frm_payload, exp_pay); else n_pass++;
    n_total++; if (mon_err - me !== 1) $display("FAIL resync_err_pulses: got %0d want 1", mon_err - me); else n_pass++;

    build_frame(8'h06, -1);
    for (int i = 0; i < 9; i++) send_byte(fb[i], (i == 0), 1'b0);
    rx_valid = 1'b1; rx_data = fb[9]; rx_k = 1'b0; rx_code_err = 1'b0;
    reset = 1'b1;
    #1;
    n_total++; if (aligned !== 1'b0) $display("FAIL async_rst_aligned: got %b want 0", aligned); else n_pass++;
    n_total++; if (good_frame_cnt !== 16'd0) $display("FAIL async_rst_cnt: got %0d want 0", good_frame_cnt); else n_pass++;
    n_total++; if (frm_payload !== '0) $display("FAIL async_rst_payload: got %h want 0", frm_payload); else n_pass++;
    n_total++; if ({frm_valid, frm_crc_err} !== 2'b00) $display("FAIL async_rst_pulses: got %b want 00", {frm_valid, frm_crc_err}); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    mv = mon_valid; me = mon_err;
    for (int i = 10; i < FRAME_LEN; i++) send_byte(fb[i], 1'b0, 1'b0);
    idle(); idle();
    n_total++; if (mon_valid - mv !== 0) $display("FAIL partial_valid_pulses: got %0d want 0", mon_valid - mv); else n_pass++;
    n_total++; if (mon_err - me !== 0) $display("FAIL partial_err_pulses: got %0d want 0", mon_err - me); else n_pass++;
    n_total++; if (aligned !== 1'b0) $display("FAIL partial_aligned: got %b want 0", aligned); else n_pass++;
  endtask

`ifdef LTPI_RX_ERR_STATS_EN
  task automatic test_stats;
    reset = 1'b1; tick(); reset = 1'b0;
    build_frame(8'h07, -1);
    for (int f = 0; f < 3; f++) send_frame(1'b0, -1, 1'b0);
    build_frame(8'h08, 5);
    send_frame(1'b0, -1, 1'b0);
    send_frame(1'b0, -1, 1'b0);
    build_frame(8'h09, -1);
    send_frame(1'b0, 3, 1'b0);
    n_total++; if (crc_err_cnt !== 16'd2) $display("FAIL stats_crc: got %0d want 2", crc_err_cnt); else n_pass++;
    n_total++; if (code_err_cnt !== 16'd1) $display("FAIL stats_code: got %0d want 1", code_err_cnt); else n_pass++;
    n_total++; if (unlock_cnt !== 8'd0) $display("FAIL stats_unlock: got %0d want 0", unlock_cnt); else n_pass++;
    build_frame(8'h0A, 5);
    send_frame(1'b0, -1, 1'b1);
    n_total++; if (crc_err_cnt !== 16'd0) $display("FAIL stats_clr_crc: got %0d want 0", crc_err_cnt); else n_pass++;
    n_total++; if (code_err_cnt !== 16'd0) $display("FAIL stats_clr_code: got %0d want 0", code_err_cnt); else n_pass++;
    n_total++; if (unlock_cnt !== 8'd0) $display("FAIL stats_clr_unlock: got %0d want 0", unlock_cnt); else n_pass++;
    n_total++; if (aligned !== 1'b0) $display("FAIL stats_aligned: got %b want 0", aligned); else n_pass++;
    send_frame(1'b0, -1, 1'b0);
    n_total++; if (crc_err_cnt !== 16'd1) $display("FAIL stats_resume: got %0d want 1", crc_err_cnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_clean_lock();
    test_crc_error();
    test_unlock();
    test_gaps();
    test_midframe_comma_reset();
`ifdef LTPI_RX_ERR_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
